// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states,
// decoded instruction classes, select constants and the output bundle.
package ctrl_pkg;

    typedef enum logic [2:0] {WAIT, LOAD_A, LOAD_B, EXEC, WB} state_t;

    typedef enum logic [2:0] {
        CLS_MOVI, CLS_MOVR, CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN, CLS_ILL
    } cls_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] MOV_IMM = 2'b10;

    localparam logic [1:0] REG_SEL_RM = 2'b00;
    localparam logic [1:0] REG_SEL_RD = 2'b01;
    localparam logic [1:0] REG_SEL_RN = 2'b10;
    localparam logic [1:0] WB_SEL_C   = 2'b00;
    localparam logic [1:0] WB_SEL_IMM = 2'b10;

    typedef struct packed {
        logic       waiting;
        logic [1:0] reg_sel;
        logic [1:0] wb_sel;
        logic       w_en;
        logic       en_A;
        logic       en_B;
        logic       en_C;
        logic       en_status;
        logic       sel_A;
        logic       sel_B;
        logic [1:0] shift_sel;
        logic       done;
    } ctrl_out_t;

    localparam ctrl_out_t OUT_IDLE = '{waiting: 1'b1, default: '0};

    function automatic cls_t decode_cls(input logic [2:0] opc, input logic [1:0] op);
        cls_t c;
        c = CLS_ILL;
        if (opc == OPC_MOV) begin
            if (op == MOV_IMM)      c = CLS_MOVI;
            else if (op == MOV_REG) c = CLS_MOVR;
        end else if (opc == OPC_ALU) begin
            case (op)
                ALU_ADD: c = CLS_ADD;
                ALU_CMP: c = CLS_CMP;
                ALU_AND: c = CLS_AND;
                default: c = CLS_MVN;
            endcase
        end
        return c;
    endfunction

    // Output bundle for a state; `last` marks the final ALU_LAT cycle of EXEC.
    function automatic ctrl_out_t state_outs(input state_t s, input cls_t c,
                                             input logic [1:0] sh, input logic last);
        ctrl_out_t o;
        o = '0;
        case (s)
            WAIT: o.waiting = 1'b1;
            LOAD_A: begin
                o.reg_sel = REG_SEL_RN;
                o.en_A    = 1'b1;
            end
            LOAD_B: begin
                o.reg_sel = REG_SEL_RM;
                o.en_B    = 1'b1;
            end
            EXEC: begin
                o.shift_sel = sh;
                o.sel_A     = (c == CLS_MOVR);
                if (last) begin
                    if (c == CLS_CMP) begin
                        o.en_status = 1'b1;
                        o.done      = 1'b1;
                    end else begin
                        o.en_C = 1'b1;
                    end
                end
            end
            WB: begin
                o.reg_sel = (c == CLS_MOVI) ? REG_SEL_RN : REG_SEL_RD;
                o.wb_sel  = (c == CLS_MOVI) ? WB_SEL_IMM : WB_SEL_C;
                o.w_en    = 1'b1;
                o.done    = 1'b1;
            end
            default: o = OUT_IDLE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/exec_timer.sv
// EXEC-phase cycle counter: holds at 0 outside EXEC, counts 0..ALU_LAT-1 inside,
// and flags the last and next-to-last cycles so outputs can be registered ahead.
module exec_timer #(
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_last,
    output logic o_pre_last
);
    localparam int CW = $clog2(ALU_LAT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !i_run)
            r_cnt <= '0;
        else if (!o_last)
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_last = (r_cnt == CW'(ALU_LAT - 1));

    generate
        if (ALU_LAT > 1) begin : g_multi
            assign o_pre_last = (r_cnt == CW'(ALU_LAT - 2));
        end else begin : g_single
            assign o_pre_last = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle datapath controller: Moore FSM with registered outputs.
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic [1:0]       ALU_op,
    input  logic [1:0]       shift_op,
    output logic             waiting,
    output logic [1:0]       reg_sel,
    output logic [1:0]       wb_sel,
    output logic             w_en,
    output logic             en_A,
    output logic             en_B,
    output logic             en_C,
    output logic             en_status,
    output logic             sel_A,
    output logic             sel_B,
    output logic [1:0]       shift_sel,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);
    state_t     r_state, w_nxt_state;
    cls_t       r_cls, w_nxt_cls, w_dec_cls;
    logic [1:0] r_shift, w_nxt_shift;
    ctrl_out_t  r_out;
    logic       r_illegal;
    logic       w_run, w_last, w_pre_last, w_nxt_last, w_accept;

    assign w_dec_cls = decode_cls(opcode, ALU_op);
    assign w_accept  = (r_state == WAIT) && start;
    assign w_run     = (r_state == EXEC);

    exec_timer #(.ALU_LAT(ALU_LAT)) u_exec_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (w_run),
        .o_last     (w_last),
        .o_pre_last (w_pre_last)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cls   = r_cls;
        w_nxt_shift = r_shift;
        w_nxt_last  = 1'b0;
        case (r_state)
            WAIT: if (start) begin
                w_nxt_cls   = w_dec_cls;
                w_nxt_shift = shift_op;
                case (w_dec_cls)
                    CLS_MOVI:                   w_nxt_state = WB;
                    CLS_MOVR, CLS_MVN:          w_nxt_state = LOAD_B;
                    CLS_ADD, CLS_AND, CLS_CMP:  w_nxt_state = LOAD_A;
                    default:                    w_nxt_state = WAIT;
                endcase
            end
            LOAD_A: w_nxt_state = LOAD_B;
            LOAD_B: w_nxt_state = EXEC;
            EXEC:   if (w_last) w_nxt_state = (r_cls == CLS_CMP) ? WAIT : WB;
            WB:     w_nxt_state = WAIT;
            default: w_nxt_state = WAIT;
        endcase
        // Outputs are registered, so the last-EXEC flag is predicted one cycle early.
        if (w_nxt_state == EXEC)
            w_nxt_last = (r_state == EXEC) ? w_pre_last : (ALU_LAT == 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= WAIT;
            r_cls     <= CLS_ILL;
            r_shift   <= '0;
            r_out     <= OUT_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cls     <= w_nxt_cls;
            r_shift   <= w_nxt_shift;
            r_out     <= state_outs(w_nxt_state, w_nxt_cls, w_nxt_shift, w_nxt_last);
            r_illegal <= w_accept && (w_dec_cls == CLS_ILL);
        end
    end

    assign waiting   = r_out.waiting;
    assign reg_sel   = r_out.reg_sel;
    assign wb_sel    = r_out.wb_sel;
    assign w_en      = r_out.w_en;
    assign en_A      = r_out.en_A;
    assign en_B      = r_out.en_B;
    assign en_C      = r_out.en_C;
    assign en_status = r_out.en_status;
    assign sel_A     = r_out.sel_A;
    assign sel_B     = r_out.sel_B;
    assign shift_sel = r_out.shift_sel;
    assign done      = r_out.done;
    assign illegal   = r_illegal;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_instr_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_instr_cnt <= '0;
        else if (r_out.done && (r_instr_cnt != {CNT_W{1'b1}}))
            r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end

    assign instr_count = r_instr_cnt;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (ALU_LAT=1 / CNT_W=2 and ALU_LAT=3 / CNT_W=16)
// checked every cycle against a per-instruction schedule model, plus literal spot checks.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       waiting;
        logic [1:0] reg_sel;
        logic [1:0] wb_sel;
        logic       w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
        logic [1:0] shift_sel;
        logic       done, illegal;
    } vec_t;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, start;
    logic [2:0] opcode;
    logic [1:0] ALU_op, shift_op;

    logic [1:0]      waiting, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B, done, illegal;
    logic [1:0][1:0] reg_sel, wb_sel, shift_sel;
    logic [1:0]      cnt0;
    logic [15:0]     cnt1;

    int nvec = 0, nerr = 0, cyc = 0;

    // model state
    vec_t sched [2][16];
    int   slen [2], spos [2];
    vec_t expv [2], prev [2];
    int   mcnt [2];
    // per-instruction tallies
    int busy [2], nC [2], nS [2], nW [2], nD [2];

    always #5 clk = ~clk;

    multicycle_ctrl #(.ALU_LAT(1), .CNT_W(2)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
        .shift_op(shift_op), .waiting(waiting[0]), .reg_sel(reg_sel[0]), .wb_sel(wb_sel[0]),
        .w_en(w_en[0]), .en_A(en_A[0]), .en_B(en_B[0]), .en_C(en_C[0]),
        .en_status(en_status[0]), .sel_A(sel_A[0]), .sel_B(sel_B[0]),
        .shift_sel(shift_sel[0]), .done(done[0]), .illegal(illegal[0]), .instr_count(cnt0));

    multicycle_ctrl #(.ALU_LAT(3), .CNT_W(16)) dut_l3 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .ALU_op(ALU_op),
        .shift_op(shift_op), .waiting(waiting[1]), .reg_sel(reg_sel[1]), .wb_sel(wb_sel[1]),
        .w_en(w_en[1]), .en_A(en_A[1]), .en_B(en_B[1]), .en_C(en_C[1]),
        .en_status(en_status[1]), .sel_A(sel_A[1]), .sel_B(sel_B[1]),
        .shift_sel(shift_sel[1]), .done(done[1]), .illegal(illegal[1]), .instr_count(cnt1));

    function automatic vec_t idle_v();
        vec_t v;
        v = '0;
        v.waiting = 1'b1;
        return v;
    endfunction

    function automatic vec_t obs(input int d);
        vec_t v;
        v.waiting = waiting[d];   v.reg_sel = reg_sel[d]; v.wb_sel = wb_sel[d];
        v.w_en = w_en[d];         v.en_A = en_A[d];       v.en_B = en_B[d];
        v.en_C = en_C[d];         v.en_status = en_status[d];
        v.sel_A = sel_A[d];       v.sel_B = sel_B[d];     v.shift_sel = shift_sel[d];
        v.done = done[d];         v.illegal = illegal[d];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, got, want);
        end
    endtask

    task automatic push(input int d, input vec_t v);
        sched[d][slen[d]] = v;
        slen[d]++;
    endtask

    // Expected per-cycle outputs for one accepted legal instruction.
    task automatic build(input int d, input logic [2:0] opc, input logic [1:0] op, input logic [1:0] sh);
        vec_t v;
        int   lat;
        bit   movi, movr, cmp, has_a;
        lat   = (d == 0) ? 1 : 3;
        movi  = (opc == 3'b110) && (op == 2'b10);
        movr  = (opc == 3'b110) && (op == 2'b00);
        cmp   = (opc == 3'b101) && (op == 2'b01);
        has_a = (opc == 3'b101) && (op != 2'b11);
        slen[d] = 0;
        spos[d] = 0;
        if (movi) begin
            v = '0; v.reg_sel = 2'b10; v.wb_sel = 2'b10; v.w_en = 1'b1; v.done = 1'b1;
            push(d, v);
        end else begin
            if (has_a) begin
                v = '0; v.reg_sel = 2'b10; v.en_A = 1'b1; push(d, v);
            end
            v = '0; v.reg_sel = 2'b00; v.en_B = 1'b1; push(d, v);
            for (int i = 0; i < lat; i++) begin
                v = '0; v.shift_sel = sh; v.sel_A = movr;
                if (i == lat - 1) begin
                    if (cmp) begin v.en_status = 1'b1; v.done = 1'b1; end
                    else v.en_C = 1'b1;
                end
                push(d, v);
            end
            if (!cmp) begin
                v = '0; v.reg_sel = 2'b01; v.w_en = 1'b1; v.done = 1'b1; push(d, v);
            end
        end
    endtask

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic advance();
        bit legal;
        int cmax;
        legal = ((opcode == 3'b110) && (ALU_op == 2'b10 || ALU_op == 2'b00)) || (opcode == 3'b101);
        for (int d = 0; d < 2; d++) begin
            cmax = (d == 0) ? 3 : 65535;
            if (!rst_n) begin
                slen[d] = 0; spos[d] = 0; mcnt[d] = 0;
                expv[d] = idle_v();
            end else begin
                if (PERF && prev[d].done && mcnt[d] < cmax) mcnt[d]++;
                if (prev[d].waiting && start) begin
                    if (legal) begin
                        build(d, opcode, ALU_op, shift_op);
                        expv[d] = sched[d][0];
                        spos[d] = 1;
                    end else begin
                        expv[d] = idle_v();
                        expv[d].illegal = 1'b1;
                    end
                end else if (spos[d] < slen[d]) begin
                    expv[d] = sched[d][spos[d]];
                    spos[d]++;
                end else begin
                    expv[d] = idle_v();
                end
            end
            prev[d] = expv[d];
        end
    endtask

    task automatic step();
        advance();
        @(posedge clk);
        #1;
        cyc++;
        chk("outputs_L1", obs(0), expv[0]);
        chk("outputs_L3", obs(1), expv[1]);
        chk("count_L1", {30'd0, cnt0}, mcnt[0]);
        chk("count_L3", {16'd0, cnt1}, mcnt[1]);
        for (int d = 0; d < 2; d++) begin
            if (!waiting[d]) busy[d]++;
            nC[d] += en_C[d]; nS[d] += en_status[d]; nW[d] += w_en[d]; nD[d] += done[d];
        end
    endtask

    task automatic clr_tally();
        for (int d = 0; d < 2; d++) begin
            busy[d] = 0; nC[d] = 0; nS[d] = 0; nW[d] = 0; nD[d] = 0;
        end
    endtask

    // Issue one instruction and run until both instances are idle; optionally
    // pulse start with a different opcode on the second and third cycles.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] op, input logic [1:0] sh,
                             input bit interfere);
        int n;
        clr_tally();
        opcode = opc; ALU_op = op; shift_op = sh; start = 1'b1;
        step();
        start = 1'b0;
        n = 1;
        while (!(waiting[0] && waiting[1]) && n < 20) begin
            if (interfere && (n == 1 || n == 2)) begin
                start = 1'b1; opcode = 3'b110; ALU_op = 2'b10; shift_op = 2'b11;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        chk("idle_within_bound", {31'd0, waiting[0] & waiting[1]}, 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            slen[d] = 0; spos[d] = 0; mcnt[d] = 0;
            expv[d] = idle_v(); prev[d] = idle_v();
        end
        clr_tally();
        rst_n = 1'b0; start = 1'b0; opcode = 3'b000; ALU_op = 2'b00; shift_op = 2'b00;
        step(); step();
        chk("reset_outs_L1", obs(0), 16'h8000);
        chk("reset_outs_L3", obs(1), 16'h8000);
        chk("reset_cnt", {16'd0, cnt1}, 0);
        rst_n = 1'b1;
        step();

        // MOV imm: single WB cycle
        opcode = 3'b110; ALU_op = 2'b10; shift_op = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        chk("movi_w_en", {31'd0, w_en[0]}, 1);
        chk("movi_reg_sel", {30'd0, reg_sel[0]}, 2);
        chk("movi_wb_sel", {30'd0, wb_sel[0]}, 2);
        chk("movi_done", {31'd0, done[0]}, 1);
        step();
        chk("movi_waiting_after", {31'd0, waiting[0]}, 1);

        run_instr(3'b101, 2'b00, 2'b01, 1'b0);    // ADD
        chk("add_busy_L3", busy[1], 6);
        chk("add_busy_L1", busy[0], 4);
        chk("add_enC_L3", nC[1], 1);
        chk("add_wen_L3", nW[1], 1);

        run_instr(3'b101, 2'b01, 2'b10, 1'b0);    // CMP
        chk("cmp_en_status", nS[1], 1);
        chk("cmp_en_C", nC[1], 0);
        chk("cmp_w_en", nW[1], 0);
        chk("cmp_done", nD[1], 1);
        chk("cmp_busy_L3", busy[1], 5);

        run_instr(3'b101, 2'b00, 2'b11, 1'b1);    // ADD with start pulsed while busy
        chk("busy_ign_L3", busy[1], 6);
        chk("busy_ign_L1", busy[0], 4);
        chk("busy_ign_wen", nW[1], 1);

        opcode = 3'b000; ALU_op = 2'b00; start = 1'b1;
        step();
        start = 1'b0;
        chk("illegal_pulse", {30'd0, illegal}, 3);
        chk("illegal_waiting", {30'd0, waiting}, 3);
        step();
        chk("illegal_once", {30'd0, illegal}, 0);

        run_instr(3'b110, 2'b00, 2'b01, 1'b0);    // MOV reg
        chk("movr_busy_L3", busy[1], 5);
        run_instr(3'b101, 2'b11, 2'b10, 1'b0);    // MVN
        chk("mvn_busy_L3", busy[1], 5);
        run_instr(3'b101, 2'b10, 2'b11, 1'b0);    // AND
        chk("and_busy_L3", busy[1], 6);
        run_instr(3'b111, 2'b10, 2'b00, 1'b0);    // unused opcode
        run_instr(3'b110, 2'b11, 2'b00, 1'b0);    // unused MOV sub-type

        // back-to-back MOV imm with start held high
        opcode = 3'b110; ALU_op = 2'b10; start = 1'b1;
        for (int i = 0; i < 5; i++) step();
        start = 1'b0;
        step();

        // reset during EXEC
        opcode = 3'b101; ALU_op = 2'b00; shift_op = 2'b01; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        chk("rst_exec_waiting", {30'd0, waiting}, 3);
        chk("rst_exec_wen", {30'd0, w_en}, 0);
        rst_n = 1'b1;
        clr_tally();
        for (int i = 0; i < 5; i++) step();
        chk("rst_exec_no_write", nW[1] + nW[0], 0);

        // reset wins over simultaneous start
        rst_n = 1'b0; start = 1'b1; opcode = 3'b110; ALU_op = 2'b10;
        step();
        chk("rst_prio_waiting", {30'd0, waiting}, 3);
        chk("rst_prio_wen", {30'd0, w_en}, 0);
        rst_n = 1'b1; start = 1'b0;
        step();

        run_instr(3'b110, 2'b10, 2'b00, 1'b0);
        run_instr(3'b101, 2'b00, 2'b00, 1'b0);
        run_instr(3'b101, 2'b01, 2'b00, 1'b0);
        step();
        chk("count_three", {16'd0, cnt1}, PERF ? 3 : 0);
        run_instr(3'b110, 2'b10, 2'b00, 1'b0);
        run_instr(3'b110, 2'b10, 2'b00, 1'b0);
        step();
        chk("count_sat_L1", {30'd0, cnt0}, PERF ? 3 : 0);
        chk("count_five_L3", {16'd0, cnt1}, PERF ? 5 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
